// File: rtl/mpc_pkg.sv
// Shared types and constants for the multi-project-chip configuration controller.
// Register offsets are word indices taken from wbs_adr_i[3:2].
package mpc_pkg;

  localparam int CFG_W  = 4;
  localparam int NMACRO = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_SETTLE  = 2'd3
  } mpc_state_e;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_SWRST  = 2'd2;

  localparam int APPLY_BIT   = 8;
  localparam int ERR_CLR_BIT = 9;
  localparam int BUSY_BIT    = 8;
  localparam int ERR_BIT     = 9;
  localparam int COUNT_LSB   = 16;

  function automatic logic [31:0] status_word(input logic [CFG_W-1:0] cfg,
                                              input logic busy,
                                              input logic err,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[CFG_W-1:0]            = cfg;
    w[BUSY_BIT]             = busy;
    w[ERR_BIT]              = err;
    w[COUNT_LSB+7:COUNT_LSB] = count;
    return w;
  endfunction

endpackage

// File: rtl/mpc_cfg_regs.sv
// Wishbone slave: address decode, single-cycle ack, register file and read mux.
// Emits a one-cycle apply request together with the value pending will hold.
module mpc_cfg_regs
  import mpc_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_i,
  input  logic              cyc_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       dat_i,
  input  logic [31:0]       adr_i,
  output logic              ack_o,
  output logic [31:0]       dat_o,
  input  logic              busy_i,
  input  logic [CFG_W-1:0]  active_cfg_i,
  input  logic [7:0]        switch_cnt_i,
  output logic              apply_req_o,
  output logic [CFG_W-1:0]  apply_cfg_o,
  output logic [NMACRO-1:0] swrst_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [CFG_W-1:0]  pending_q, pending_d;
  logic [NMACRO-1:0] swrst_q, swrst_d;
  logic              err_q, err_d;
  logic              accept, ctrl_wr, err_clr;
  logic [1:0]        ofs;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^{adr_i[1:0], dat_i[31:10], dat_i[7:CFG_W], sel_i[3:2]};

  always_comb begin
    ofs       = adr_i[3:2];
    // The ~ack term makes a held strobe complete once every other cycle.
    accept    = stb_i & cyc_i & ~ack_q & (adr_i[31:4] == BASE_ADR[31:4]);
    ctrl_wr   = accept & we_i & (ofs == OFS_CTRL);
    err_clr   = ctrl_wr & sel_i[1] & dat_i[ERR_CLR_BIT];
    apply_req_o = ctrl_wr & sel_i[1] & dat_i[APPLY_BIT];

    pending_d = pending_q;
    if (ctrl_wr && sel_i[0]) pending_d = dat_i[CFG_W-1:0];
    apply_cfg_o = pending_d;

    swrst_d = swrst_q;
    if (accept && we_i && ofs == OFS_SWRST && sel_i[0]) swrst_d = dat_i[NMACRO-1:0];

    // A rejected apply wins over a clear arriving in the same write.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (apply_req_o && busy_i) err_d = 1'b1;

    rdata = '0;
    case (ofs)
      OFS_CTRL:   rdata = {{(32-CFG_W){1'b0}}, pending_q};
      OFS_STATUS: rdata = status_word(active_cfg_i, busy_i, err_q, switch_cnt_i);
      OFS_SWRST:  rdata = {{(32-NMACRO){1'b0}}, swrst_q};
      default:    rdata = '0;
    endcase

    ack_d = accept;
    dat_d = (accept && !we_i) ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      pending_q <= '0;
      swrst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      pending_q <= pending_d;
      swrst_q   <= swrst_d;
      err_q     <= err_d;
    end
  end

  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign swrst_o = swrst_q;

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// Configuration select controller: every change of configuration is wrapped in a
// quiesce / switch / settle sequence with pad enables blocked and macros in reset.
module mpc_cfg_ctrl
  import mpc_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter int unsigned QUIESCE_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [CFG_W-1:0]  configuration,
  output logic              pad_oe_block,
  output logic [NMACRO-1:0] macro_rst_o,
  output logic              busy
);

  localparam logic [7:0] RELOAD = 8'(QUIESCE_CYCLES - 1);

  mpc_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CFG_W-1:0]  target_q, target_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [7:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              apply_req;
  logic [CFG_W-1:0]  apply_cfg;
  logic [NMACRO-1:0] swrst;

  mpc_cfg_regs #(.BASE_ADR(BASE_ADR)) u_regs (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .stb_i        (wbs_stb_i),
    .cyc_i        (wbs_cyc_i),
    .we_i         (wbs_we_i),
    .sel_i        (wbs_sel_i),
    .dat_i        (wbs_dat_i),
    .adr_i        (wbs_adr_i),
    .ack_o        (wbs_ack_o),
    .dat_o        (wbs_dat_o),
    .busy_i       (busy_q),
    .active_cfg_i (cfg_q),
    .switch_cnt_i (count_q),
    .apply_req_o  (apply_req),
    .apply_cfg_o  (apply_cfg),
    .swrst_o      (swrst)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    cfg_d    = cfg_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        // Target is latched here so pending writes during the sequence cannot leak in.
        if (apply_req) begin
          state_d  = ST_QUIESCE;
          cnt_d    = RELOAD;
          target_d = apply_cfg;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == 8'd0) state_d = ST_SWITCH;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_SWITCH: begin
        cfg_d   = target_q;
        count_d = count_q + 8'd1;
        cnt_d   = RELOAD;
        state_d = ST_SETTLE;
      end
      default: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Reset lands in SETTLE so macros stay held and pads blocked after power-up.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= RELOAD;
      target_q <= '0;
      cfg_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cfg_q    <= cfg_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign configuration = cfg_q;
  assign busy          = busy_q;
  assign pad_oe_block  = busy_q;
  assign macro_rst_o   = swrst | {NMACRO{busy_q}};

endmodule
